// File: rtl/chacha_keystream_gen_if.sv
// Job request / keystream handshake bundle for chacha_keystream_gen.
// Optional port hchacha exists only when CHACHA_HCHACHA_EN is defined.
interface chacha_keystream_gen_if;
   localparam int unsigned KEY_W   = 256;
   localparam int unsigned NONCE_W = 96;
   localparam int unsigned CTR_W   = 32;
   localparam int unsigned NBLK_W  = 16;
   localparam int unsigned DATA_W  = 512;

   logic                 start_valid;
   logic                 start_ready;
   logic [KEY_W-1:0]     key;
   logic [NONCE_W-1:0]   nonce;
   logic [CTR_W-1:0]     ctr_init;
   logic [NBLK_W-1:0]    nblocks;
   logic                 ks_valid;
   logic                 ks_ready;
   logic [DATA_W-1:0]    ks_data;
   logic                 ks_last;
   logic                 ctr_ovf;
   logic                 busy;
`ifdef CHACHA_HCHACHA_EN
   logic                 hchacha;

   modport master (output start_valid, key, nonce, ctr_init, nblocks, ks_ready, hchacha,
                   input  start_ready, ks_valid, ks_data, ks_last, ctr_ovf, busy);
   modport slave  (input  start_valid, key, nonce, ctr_init, nblocks, ks_ready, hchacha,
                   output start_ready, ks_valid, ks_data, ks_last, ctr_ovf, busy);
`else
   modport master (output start_valid, key, nonce, ctr_init, nblocks, ks_ready,
                   input  start_ready, ks_valid, ks_data, ks_last, ctr_ovf, busy);
   modport slave  (input  start_valid, key, nonce, ctr_init, nblocks, ks_ready,
                   output start_ready, ks_valid, ks_data, ks_last, ctr_ovf, busy);
`endif
endinterface

// File: rtl/chacha_keystream_gen.sv
// ChaCha keystream block generator: iterative double-round core with
// feedforward, multi-block jobs with counter increment and wrap termination.
// Optional HChaCha mode (raw permuted state, single block) under CHACHA_HCHACHA_EN.
module chacha_keystream_gen #(
   parameter int unsigned ROUNDS       = 20,
   parameter int unsigned DR_PER_CYCLE = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   chacha_keystream_gen_if.slave bus
);
   localparam int unsigned N_CYC = ROUNDS / (2 * DR_PER_CYCLE);
   localparam int unsigned CNT_W = $clog2(N_CYC + 1);
   localparam int unsigned REM_W = 17;

   typedef logic [15:0][31:0] state_t;
   typedef enum logic [1:0] {IDLE, ROUND, OUT} fsm_e;

   if (!((ROUNDS == 8) || (ROUNDS == 12) || (ROUNDS == 20))) begin : g_bad_rounds
      $error("chacha_keystream_gen: ROUNDS must be 8, 12 or 20");
   end
   if ((DR_PER_CYCLE == 0) || (((ROUNDS / 2) % DR_PER_CYCLE) != 0)) begin : g_bad_dr
      $error("chacha_keystream_gen: DR_PER_CYCLE must divide ROUNDS/2");
   end

   fsm_e             fsm_q, fsm_d;
   state_t           work_q, work_d;
   state_t           ff_q, ff_d;
   logic [REM_W-1:0] remain_q, remain_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   state_t           ks_data_q, ks_data_d;
   logic             ks_valid_q, ks_valid_d;
   logic             ks_last_q, ks_last_d;
   logic             ctr_ovf_q, ctr_ovf_d;
   logic             hch_q, hch_d;
   logic             start_ready_q, start_ready_d;
   logic             busy_q, busy_d;
   state_t           init_st;
   state_t           dr_st;
   state_t           sum_st;

   function automatic logic [3:0][31:0] quarter_round(input logic [31:0] a_in, b_in, c_in, d_in);
      logic [31:0] a, b, c, d;
      a = a_in; b = b_in; c = c_in; d = d_in;
      a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
      c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
      a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
      c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
      return {d, c, b, a};
   endfunction

   // Column round followed by diagonal round; diagonal i uses (i, 4+(i+1)%4, 8+(i+2)%4, 12+(i+3)%4).
   function automatic state_t double_round(input state_t s);
      state_t           t;
      logic [3:0][31:0] q;
      logic [3:0]       ia, ib, ic, id;
      t = s;
      for (int i = 0; i < 4; i++) begin
         ia = 4'(i); ib = 4'(4 + i); ic = 4'(8 + i); id = 4'(12 + i);
         q = quarter_round(t[ia], t[ib], t[ic], t[id]);
         t[ia] = q[0]; t[ib] = q[1]; t[ic] = q[2]; t[id] = q[3];
      end
      for (int i = 0; i < 4; i++) begin
         ia = 4'(i); ib = 4'(4 + ((i + 1) % 4)); ic = 4'(8 + ((i + 2) % 4)); id = 4'(12 + ((i + 3) % 4));
         q = quarter_round(t[ia], t[ib], t[ic], t[id]);
         t[ia] = q[0]; t[ib] = q[1]; t[ic] = q[2]; t[id] = q[3];
      end
      return t;
   endfunction

   // Initial state built from the job inputs plus the ChaCha constants.
   always_comb begin
      init_st        = '0;
      init_st[0]     = 32'h61707865;
      init_st[1]     = 32'h3320646e;
      init_st[2]     = 32'h79622d32;
      init_st[3]     = 32'h6b206574;
      init_st[11:4]  = bus.key;
      init_st[12]    = bus.ctr_init;
      init_st[15:13] = bus.nonce;
   end

   // Unrolled double-rounds for one cycle and the feedforward sum.
   always_comb begin
      dr_st  = work_q;
      sum_st = '0;
      for (int unsigned d = 0; d < DR_PER_CYCLE; d++) dr_st = double_round(dr_st);
      for (int unsigned i = 0; i < 16; i++) begin
         sum_st[4'(i)] = hch_q ? dr_st[4'(i)] : dr_st[4'(i)] + ff_q[4'(i)];
      end
   end

   // Next-state and datapath control. ROUND entered from a start spends one
   // alignment cycle (cnt 0) before the N round cycles; re-entry from OUT starts at 1.
   always_comb begin
      fsm_d      = fsm_q;
      work_d     = work_q;
      ff_d       = ff_q;
      remain_d   = remain_q;
      cnt_d      = cnt_q;
      ks_data_d  = ks_data_q;
      ks_valid_d = ks_valid_q;
      ks_last_d  = ks_last_q;
      ctr_ovf_d  = ctr_ovf_q;
      hch_d      = hch_q;
      unique case (fsm_q)
         IDLE: begin
            if (bus.start_valid) begin
               ff_d     = init_st;
               work_d   = init_st;
               remain_d = (bus.nblocks == 16'd0) ? REM_W'(65536) : REM_W'(bus.nblocks);
               cnt_d    = '0;
`ifdef CHACHA_HCHACHA_EN
               hch_d    = bus.hchacha;
`else
               hch_d    = 1'b0;
`endif
               fsm_d    = ROUND;
            end
         end
         ROUND: begin
            if (cnt_q == '0) begin
               cnt_d = CNT_W'(1);
            end else begin
               work_d = dr_st;
               if (cnt_q == CNT_W'(N_CYC)) begin
                  ks_data_d  = sum_st;
                  ks_valid_d = 1'b1;
                  ctr_ovf_d  = &ff_q[12];
                  ks_last_d  = (remain_q == REM_W'(1)) || (&ff_q[12]) || hch_q;
                  fsm_d      = OUT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         OUT: begin
            if (bus.ks_ready) begin
               ks_valid_d = 1'b0;
               if (ks_last_q) begin
                  fsm_d = IDLE;
               end else begin
                  ff_d[12]   = ff_q[12] + 32'd1;
                  work_d     = ff_q;
                  work_d[12] = ff_q[12] + 32'd1;
                  remain_d   = remain_q - REM_W'(1);
                  cnt_d      = CNT_W'(1);
                  fsm_d      = ROUND;
               end
            end
         end
         default: fsm_d = IDLE;
      endcase
      start_ready_d = (fsm_d == IDLE);
      busy_d        = (fsm_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q         <= IDLE;
         work_q        <= '0;
         ff_q          <= '0;
         remain_q      <= '0;
         cnt_q         <= '0;
         ks_data_q     <= '0;
         ks_valid_q    <= 1'b0;
         ks_last_q     <= 1'b0;
         ctr_ovf_q     <= 1'b0;
         hch_q         <= 1'b0;
         start_ready_q <= 1'b1;
         busy_q        <= 1'b0;
      end else begin
         fsm_q         <= fsm_d;
         work_q        <= work_d;
         ff_q          <= ff_d;
         remain_q      <= remain_d;
         cnt_q         <= cnt_d;
         ks_data_q     <= ks_data_d;
         ks_valid_q    <= ks_valid_d;
         ks_last_q     <= ks_last_d;
         ctr_ovf_q     <= ctr_ovf_d;
         hch_q         <= hch_d;
         start_ready_q <= start_ready_d;
         busy_q        <= busy_d;
      end
   end

   assign bus.start_ready = start_ready_q;
   assign bus.busy        = busy_q;
   assign bus.ks_valid    = ks_valid_q;
   assign bus.ks_data     = ks_data_q;
   assign bus.ks_last     = ks_last_q;
   assign bus.ctr_ovf     = ctr_ovf_q;
endmodule

// File: tb/tb_chacha_keystream_gen.sv
// Self-checking bench for chacha_keystream_gen: reference ChaCha model,
// scoreboard of expected blocks, directed latency/backpressure/wrap/reset steps.
module tb_chacha_keystream_gen;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   chacha_keystream_gen_if bus ();
   chacha_keystream_gen_if bus8 ();
   chacha_keystream_gen_if bus12 ();

   chacha_keystream_gen #(.ROUNDS(20), .DR_PER_CYCLE(1)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
   chacha_keystream_gen #(.ROUNDS(8),  .DR_PER_CYCLE(2)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
   chacha_keystream_gen #(.ROUNDS(12), .DR_PER_CYCLE(1)) dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12));

   typedef struct packed {
      logic [511:0] data;
      logic         last;
      logic         ovf;
   } exp_t;

   exp_t         sb[$];
   int           checks   = 0;
   int           failures = 0;
   logic [511:0] last_data;
   logic [255:0] rfc_key;
   logic [95:0]  rfc_nonce;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // Straightforward reference: rounds alternate column / diagonal quarter-round sets.
   function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                              input logic [31:0] c, input int rounds);
      logic [31:0]  x[16];
      logic [31:0]  init[16];
      int           qi[8][4];
      logic [511:0] r;
      qi = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
             '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
      init[0] = 32'h61707865; init[1] = 32'h3320646e;
      init[2] = 32'h79622d32; init[3] = 32'h6b206574;
      for (int j = 0; j < 8; j++) init[4 + j] = k[32*j +: 32];
      init[12] = c;
      for (int j = 0; j < 3; j++) init[13 + j] = n[32*j +: 32];
      x = init;
      for (int rr = 0; rr < rounds; rr++) begin
         for (int q = 0; q < 4; q++) begin
            int a, b, cc, d, row;
            row = (rr % 2) * 4 + q;
            a = qi[row][0]; b = qi[row][1]; cc = qi[row][2]; d = qi[row][3];
            x[a] = x[a] + x[b];   x[d] = rotl(x[d] ^ x[a], 16);
            x[cc] = x[cc] + x[d]; x[b] = rotl(x[b] ^ x[cc], 12);
            x[a] = x[a] + x[b];   x[d] = rotl(x[d] ^ x[a], 8);
            x[cc] = x[cc] + x[d]; x[b] = rotl(x[b] ^ x[cc], 7);
         end
      end
      for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + init[i];
      return r;
   endfunction

   task automatic push_job(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c0,
                           input logic [15:0] nb);
      int          cnt;
      logic [31:0] c;
      exp_t        e;
      cnt = (nb == 16'd0) ? 65536 : int'(nb);
      for (int i = 0; i < cnt; i++) begin
         c      = c0 + 32'(i);
         e.data = ref_block(k, n, c, 20);
         e.ovf  = (c == 32'hFFFFFFFF);
         e.last = (i == cnt - 1) || e.ovf;
         sb.push_back(e);
         if (e.last) break;
      end
   endtask

   // Drive a request and complete the handshake; returns #1 after the handshake edge.
   task automatic start_job(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c0,
                            input logic [15:0] nb);
      bus.key = k; bus.nonce = n; bus.ctr_init = c0; bus.nblocks = nb;
      bus.start_valid = 1'b1;
      check("start_ready_before_job", 512'(bus.start_ready), 512'(1'b1));
      @(posedge clk); #1;
      bus.start_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!bus.ks_valid && n < 200);
   endtask

   task automatic sb_compare(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++; failures++;
         $error("FAIL %s scoreboard_empty observed=%0h expected=none", tag, bus.ks_data);
      end else begin
         e = sb.pop_front();
         check({tag, "_data"}, bus.ks_data, e.data);
         check({tag, "_last"}, 512'(bus.ks_last), 512'(e.last));
         check({tag, "_ovf"},  512'(bus.ks_valid & bus.ctr_ovf), 512'(e.ovf));
      end
      last_data = bus.ks_data;
   endtask

   // Collect nblk blocks with ks_ready high, each expected 'gap' edges after the previous event.
   task automatic collect(input string tag, input int nblk, input int gap);
      int n;
      for (int b = 0; b < nblk; b++) begin
         wait_valid(n);
         check($sformatf("%s_lat%0d", tag, b), 512'(n), 512'(gap));
         sb_compare($sformatf("%s_blk%0d", tag, b));
      end
   endtask

   task automatic check_idle_after(input string tag);
      @(posedge clk); #1;
      check({tag, "_ks_valid_low"}, 512'(bus.ks_valid), 512'(1'b0));
      check({tag, "_start_ready"},  512'(bus.start_ready), 512'(1'b1));
      check({tag, "_busy_low"},     512'(bus.busy), 512'(1'b0));
   endtask

   initial begin
      int           n;
      int           lat8, lat12;
      logic [511:0] d0, d8, d12;

      for (int j = 0; j < 32; j++) rfc_key[8*j +: 8] = 8'(j);
      rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};

      rst_n = 1'b0;
      bus.start_valid = 1'b0;   bus.ks_ready = 1'b1;
      bus.key = '0; bus.nonce = '0; bus.ctr_init = '0; bus.nblocks = '0;
      bus8.start_valid = 1'b0;  bus8.ks_ready = 1'b1;
      bus8.key = '0; bus8.nonce = '0; bus8.ctr_init = '0; bus8.nblocks = '0;
      bus12.start_valid = 1'b0; bus12.ks_ready = 1'b1;
      bus12.key = '0; bus12.nonce = '0; bus12.ctr_init = '0; bus12.nblocks = '0;
`ifdef CHACHA_HCHACHA_EN
      bus.hchacha = 1'b0; bus8.hchacha = 1'b0; bus12.hchacha = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_start_ready", 512'(bus.start_ready), 512'(1'b1));
      check("rst_busy",        512'(bus.busy), 512'(1'b0));
      check("rst_ks_valid",    512'(bus.ks_valid), 512'(1'b0));
      check("rst_ks_last",     512'(bus.ks_last), 512'(1'b0));
      check("rst_ctr_ovf",     512'(bus.ctr_ovf), 512'(1'b0));
      check("rst_ks_data",     bus.ks_data, 512'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      // RFC 8439 block test vector
      push_job(rfc_key, rfc_nonce, 32'd1, 16'd1);
      start_job(rfc_key, rfc_nonce, 32'd1, 16'd1);
      check("rfc_busy", 512'(bus.busy), 512'(1'b1));
      collect("rfc", 1, 11);
      check("rfc_word0", 512'(last_data[31:0]), 512'(32'he4e7f110));
      check_idle_after("rfc");

      // Three back-to-back blocks
      push_job(rfc_key, rfc_nonce, 32'd1, 16'd3);
      start_job(rfc_key, rfc_nonce, 32'd1, 16'd3);
      collect("multi", 3, 11);
      check_idle_after("multi");

      // Counter wrap terminates the job early
      push_job(rfc_key, rfc_nonce, 32'hFFFFFFFE, 16'd5);
      start_job(rfc_key, rfc_nonce, 32'hFFFFFFFE, 16'd5);
      collect("wrap", 2, 11);
      check_idle_after("wrap");

      // Backpressure: output held stable for 20 cycles
      bus.ks_ready = 1'b0;
      push_job(~rfc_key, rfc_nonce, 32'd7, 16'd1);
      start_job(~rfc_key, rfc_nonce, 32'd7, 16'd1);
      wait_valid(n);
      check("bp_lat", 512'(n), 512'(11));
      sb_compare("bp");
      d0 = bus.ks_data;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         check($sformatf("bp_hold_valid%0d", i), 512'(bus.ks_valid), 512'(1'b1));
         check($sformatf("bp_hold_data%0d", i), bus.ks_data, d0);
      end
      bus.ks_ready = 1'b1;
      check_idle_after("bp");

      // start_valid while busy is ignored and inputs are not resampled
      push_job(rfc_key, rfc_nonce, 32'd1, 16'd1);
      start_job(rfc_key, rfc_nonce, 32'd1, 16'd1);
      bus.start_valid = 1'b1; bus.key = ~rfc_key; bus.ctr_init = 32'd0; bus.nblocks = 16'd5;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check($sformatf("busy_start_ready%0d", i), 512'(bus.start_ready), 512'(1'b0));
      end
      bus.start_valid = 1'b0; bus.key = rfc_key;
      collect("ignore", 1, 8);
      check_idle_after("ignore");

      // Asynchronous reset in the middle of ROUND
      start_job(rfc_key, rfc_nonce, 32'd1, 16'd1);
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_ks_valid",    512'(bus.ks_valid), 512'(1'b0));
      check("midrst_busy",        512'(bus.busy), 512'(1'b0));
      check("midrst_start_ready", 512'(bus.start_ready), 512'(1'b1));
      check("midrst_ks_data",     bus.ks_data, 512'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      push_job(rfc_key, rfc_nonce, 32'd1, 16'd1);
      start_job(rfc_key, rfc_nonce, 32'd1, 16'd1);
      collect("postrst", 1, 11);
      check("postrst_word0", 512'(last_data[31:0]), 512'(32'he4e7f110));
      check_idle_after("postrst");

      // Reduced-round configurations
      bus8.key = rfc_key;  bus8.nonce = rfc_nonce;  bus8.ctr_init = 32'd1;  bus8.nblocks = 16'd1;
      bus12.key = rfc_key; bus12.nonce = rfc_nonce; bus12.ctr_init = 32'd1; bus12.nblocks = 16'd1;
      bus8.start_valid = 1'b1; bus12.start_valid = 1'b1;
      @(posedge clk); #1;
      bus8.start_valid = 1'b0; bus12.start_valid = 1'b0;
      lat8 = 0; lat12 = 0; d8 = '0; d12 = '0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (bus8.ks_valid && lat8 == 0) begin lat8 = i; d8 = bus8.ks_data; end
         if (bus12.ks_valid && lat12 == 0) begin lat12 = i; d12 = bus12.ks_data; end
      end
      check("r8_lat",   512'(lat8), 512'(3));
      check("r12_lat",  512'(lat12), 512'(7));
      check("r8_data",  d8, ref_block(rfc_key, rfc_nonce, 32'd1, 8));
      check("r12_data", d12, ref_block(rfc_key, rfc_nonce, 32'd1, 12));
      check("r8_idle",  512'(bus8.start_ready), 512'(1'b1));
      check("r12_idle", 512'(bus12.start_ready), 512'(1'b1));

      check("scoreboard_drained", 512'(sb.size()), 512'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
